ex_stage_pipe: RTL

Parametrised execute stage for the WISC pipeline, sitting between the ID/EX and EX/MEM pipeline registers. It performs ALU operations, including saturating add/sub and a multi-cycle multiply, and holds the Z/V/N flag register. It resolves branch, call and return redirects and forwards its own registered result back to its operands. Valid/ready handshakes on both sides let it stall upstream while a multiply is in flight or while MEM is back-pressured.

---
 rtl/ex_stage_pipe.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_pipe.sv
// WISC execute stage: ALU with saturating add/sub and multi-cycle multiply,
// Z/V/N flags, branch/call/ret redirect, self-forwarding and valid/ready on both sides.
module ex_stage_pipe #(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 16,
  parameter int REG_AW     = 4,
  parameter int CT_W       = 12,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] rd_data_1,
  input  logic [DATA_W-1:0] rd_data_2,
  input  logic [REG_AW-1:0] rs_1,
  input  logic [REG_AW-1:0] rs_2,
  input  logic [DATA_W-1:0] sign_ext,
  input  logic [3:0]        shift,
  input  logic [7:0]        load_half_imm,
  input  logic [REG_AW-1:0] reg_rd_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              branch,
  input  logic              call,
  input  logic              ret,
  input  logic [2:0]        branch_cond,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [CT_W-1:0]   call_target,
  input  logic [PC_W-1:0]   ret_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_sw_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [2:0]        flags,
  output logic              dbg_state
);

  // Handshake: a beat moves on a side when valid & ready are both high on a rising
  // edge; in_ready never depends on in_valid, out_valid never depends on out_ready.

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_NOR = 4'd3,
                         OP_SLL = 4'd4, OP_SRL = 4'd5, OP_SRA = 4'd6, OP_LHB = 4'd7,
                         OP_LLB = 4'd8, OP_MUL = 4'd9;
  localparam logic [REG_AW-1:0] SP_IDX  = '1;
  localparam logic [DATA_W-1:0] S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] LO_MASK = {DATA_W{1'b1}} >> 8;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mul_done;

  logic                  accept, fwd_a, fwd_b, is_mul, take, redir;
  logic [3:0]            op_eff;
  logic [DATA_W-1:0]     a, b_reg, b;
  logic [DATA_W:0]       sum_ext, diff_ext;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_v, flag_upd;
  logic [PC_W-1:0]       target;
  logic [REG_AW-1:0]     dest;
  logic [DATA_W-1:0]     sw_data;

  logic [DATA_W-1:0]     mul_a, mul_b, mul_sw;
  logic [REG_AW-1:0]     mul_rd;
  logic                  mul_rw, mul_mr, mul_mw;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W:0]       prod_top;
  logic [DATA_W-1:0]     prod_lo;
  logic                  mul_v;

  assign in_ready  = (state_q == IDLE) & (!out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign dbg_state = state_q;

  // Forward only real register results; a load's data is not yet available here.
  assign fwd_a = out_valid & out_reg_write & !out_mem_read & (rs_1 == out_rd);
  assign fwd_b = out_valid & out_reg_write & !out_mem_read & (rs_2 == out_rd);
  assign a     = fwd_a ? out_result : rd_data_1;
  assign b_reg = fwd_b ? out_result : rd_data_2;
  assign b     = alu_src ? sign_ext : b_reg;

  assign op_eff   = (alu_op > OP_MUL) ? OP_ADD : alu_op;
  assign is_mul   = (op_eff == OP_MUL);
  assign sum_ext  = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign diff_ext = {a[DATA_W-1], a} - {b[DATA_W-1], b};

  always_comb begin
    alu_res  = sum_ext[DATA_W-1:0];
    alu_v    = 1'b0;
    flag_upd = 1'b0;
    case (op_eff)
      OP_ADD: begin
        flag_upd = 1'b1;
        if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
          alu_v   = 1'b1;
          alu_res = sum_ext[DATA_W] ? S_MIN : S_MAX;
        end
      end
      OP_SUB: begin
        flag_upd = 1'b1;
        alu_res  = diff_ext[DATA_W-1:0];
        if (diff_ext[DATA_W] != diff_ext[DATA_W-1]) begin
          alu_v   = 1'b1;
          alu_res = diff_ext[DATA_W] ? S_MIN : S_MAX;
        end
      end
      OP_AND: begin flag_upd = 1'b1; alu_res = a & b; end
      OP_NOR: begin flag_upd = 1'b1; alu_res = ~(a | b); end
      OP_SLL: alu_res = a << shift;
      OP_SRL: alu_res = a >> shift;
      OP_SRA: alu_res = DATA_W'($signed(a) >>> shift);
      OP_LHB: alu_res = (a & LO_MASK) | (DATA_W'(load_half_imm) << (DATA_W - 8));
      OP_LLB: alu_res = DATA_W'($signed(load_half_imm));
      default: alu_res = sum_ext[DATA_W-1:0];
    endcase
  end

  // Condition codes read the flag register as it stands when the branch is accepted.
  always_comb begin
    case (branch_cond)
      3'd0:    take = !flags[2];
      3'd1:    take = flags[2];
      3'd2:    take = !flags[2] & !flags[0];
      3'd3:    take = flags[0];
      3'd4:    take = flags[2] | !flags[0];
      3'd5:    take = flags[0] | flags[2];
      3'd6:    take = flags[1];
      default: take = 1'b1;
    endcase
  end

  assign redir   = call | ret | (branch & take);
  assign target  = call ? {pc_in[PC_W-1:CT_W], call_target}
                 : ret  ? ret_pc
                 : pc_in + PC_W'($signed(sign_ext));
  assign dest    = (call | ret) ? SP_IDX : reg_rd_in;
  assign sw_data = call ? DATA_W'(pc_in) : b_reg;

  assign prod     = (2*DATA_W)'($signed(mul_a)) * (2*DATA_W)'($signed(mul_b));
  assign prod_top = prod[2*DATA_W-1:DATA_W-1];
  assign prod_lo  = prod[DATA_W-1:0];
  assign mul_v    = !((&prod_top) | ~(|prod_top));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept & is_mul) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
        end
      end
      MUL_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!out_valid | out_ready) begin
          mul_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_sw_data    <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flags          <= '0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_sw         <= '0;
      mul_rd         <= '0;
      mul_rw         <= 1'b0;
      mul_mr         <= 1'b0;
      mul_mw         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_valid <= accept & redir;
      if (accept & redir) redirect_pc <= target;

      if (accept & is_mul) begin
        mul_a  <= a;
        mul_b  <= b;
        mul_sw <= sw_data;
        mul_rd <= dest;
        mul_rw <= reg_write_in;
        mul_mr <= mem_read_in;
        mul_mw <= mem_write_in;
      end

      if (accept & !is_mul) begin
        out_valid     <= 1'b1;
        out_result    <= alu_res;
        out_sw_data   <= sw_data;
        out_rd        <= dest;
        out_reg_write <= reg_write_in;
        out_mem_read  <= mem_read_in;
        out_mem_write <= mem_write_in;
        if (flag_upd) flags <= {alu_res == '0, alu_v, alu_res[DATA_W-1]};
      end else if (mul_done) begin
        out_valid     <= 1'b1;
        out_result    <= prod_lo;
        out_sw_data   <= mul_sw;
        out_rd        <= mul_rd;
        out_reg_write <= mul_rw;
        out_mem_read  <= mul_mr;
        out_mem_write <= mul_mw;
        flags         <= {prod_lo == '0, mul_v, prod_lo[DATA_W-1]};
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
